// File: rtl/uart_command_sequencer.sv
// Assembles command + address bytes from the UART RX stream into valid/ready sensor requests.
// Optional inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_command_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_ADDRESS    = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_data,
    input  logic [7:0] data_received,
    input  logic       request_ready,
    output logic       request_valid,
    output logic [7:0] request_command,
    output logic [7:0] request_address,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned TIMER_W = 24;

    typedef enum logic [1:0] {
        WAIT_COMMAND = 2'd0,
        WAIT_ADDRESS = 2'd1,
        ISSUE        = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic       busy_q, busy_d;
    logic       frame_error_q, frame_error_d;
    logic       overrun_q, overrun_d;
    logic       addr_ok_c;
    logic       timeout_c;

    assign addr_ok_c = (32'(data_received) <= 32'(MAX_ADDRESS));

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Timer runs only while waiting for the address; a byte in the last cycle wins.
    always_comb begin
        timer_d = timer_q;
        if (state_q != WAIT_ADDRESS) begin
            timer_d = '0;
        end else if (!has_data) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    assign timeout_c = (state_q == WAIT_ADDRESS) && !has_data && (timer_q == TIMER_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMER_W'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WAIT_COMMAND;
            valid_q       <= 1'b0;
            cmd_q         <= 8'h00;
            addr_q        <= 8'h00;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_COMMAND: begin
                if (has_data) begin
                    state_d = WAIT_ADDRESS;
                end
            end
            WAIT_ADDRESS: begin
                if (has_data) begin
                    state_d = addr_ok_c ? ISSUE : WAIT_COMMAND;
                end else if (timeout_c) begin
                    state_d = WAIT_COMMAND;
                end
            end
            ISSUE: begin
                if (request_ready) begin
                    state_d = WAIT_COMMAND;
                end
            end
            default: state_d = WAIT_COMMAND;
        endcase
    end

    // Output next values; status flags follow the state being entered.
    always_comb begin
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        valid_d       = (state_d == ISSUE);
        busy_d        = (state_d != WAIT_COMMAND);
        unique case (state_q)
            WAIT_COMMAND: begin
                if (has_data) begin
                    cmd_d = data_received;
                end
            end
            WAIT_ADDRESS: begin
                if (has_data && addr_ok_c) begin
                    addr_d = data_received;
                end
                frame_error_d = (has_data && !addr_ok_c) || timeout_c;
            end
            ISSUE: begin
                overrun_d = has_data;
            end
            default: ;
        endcase
    end

    assign request_valid   = valid_q;
    assign request_command = cmd_q;
    assign request_address = addr_q;
    assign busy            = busy_q;
    assign frame_error     = frame_error_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_uart_command_sequencer.sv
// Bench for uart_command_sequencer: directed vector table, timeout/overrun sequences, random traffic vs. model.
module tb_uart_command_sequencer;

    localparam int unsigned TO  = 16;
    localparam int unsigned MAX = 31;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       has_data = 1'b0;
    logic [7:0] data_received = 8'h00;
    logic       request_ready = 1'b0;
    logic       request_valid;
    logic [7:0] request_command;
    logic [7:0] request_address;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_command_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_ADDRESS(MAX)) dut (
        .clock          (clock),
        .reset          (reset),
        .has_data       (has_data),
        .data_received  (data_received),
        .request_ready  (request_ready),
        .request_valid  (request_valid),
        .request_command(request_command),
        .request_address(request_address),
        .busy           (busy),
        .frame_error    (frame_error),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    // Behavioural model: a held command, a pending request, and an idle-cycle count.
    bit       m_have_cmd;
    bit       m_pending;
    int       m_idle;
    bit [7:0] m_cmd, m_addr;
    bit       m_fe, m_ov;

    function automatic void model_step(input bit rst, input bit hd, input bit [7:0] d, input bit rdy);
        bit timeout_en;
`ifdef UART_CMD_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        if (rst) begin
            m_have_cmd = 0; m_pending = 0; m_idle = 0;
            m_cmd = 0; m_addr = 0; m_fe = 0; m_ov = 0;
            return;
        end
        m_fe = 0;
        m_ov = 0;
        if (m_pending) begin
            m_ov = hd;
            if (rdy) m_pending = 0;
        end else if (m_have_cmd) begin
            if (hd) begin
                m_have_cmd = 0;
                if (int'(d) <= int'(MAX)) begin
                    m_addr = d;
                    m_pending = 1;
                end else begin
                    m_fe = 1;
                end
            end else if (timeout_en) begin
                m_idle++;
                if (m_idle == int'(TO)) begin
                    m_fe = 1;
                    m_have_cmd = 0;
                end
            end
        end else if (hd) begin
            m_cmd = d;
            m_have_cmd = 1;
            m_idle = 0;
        end
    endfunction

    function automatic logic [19:0] pack(input logic v, input logic [7:0] c, input logic [7:0] a,
                                         input logic b, input logic fe, input logic ov);
        return {v, c, a, b, fe, ov};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got v/cmd/addr/busy/fe/ov=%05h expected %05h", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [19:0] dut_out();
        return pack(request_valid, request_command, request_address, busy, frame_error, overrun);
    endfunction

    // One clock cycle of stimulus, then compare against the model.
    task automatic step(input logic rst, input logic hd, input logic [7:0] d, input logic rdy);
        @(negedge clock);
        reset = rst; has_data = hd; data_received = d; request_ready = rdy;
        @(posedge clock);
        model_step(rst, hd, d, rdy);
        #1;
        check("model", dut_out(), pack(m_pending, m_cmd, m_addr, m_have_cmd | m_pending, m_fe, m_ov));
    endtask

    typedef struct {
        logic        rst;
        logic        hd;
        logic [7:0]  d;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic hd, input logic [7:0] d, input logic rdy,
                                input logic v, input logic [7:0] c, input logic [7:0] a,
                                input logic b, input logic fe, input logic ov);
        vec_t r;
        r.rst = rst; r.hd = hd; r.d = d; r.rdy = rdy;
        r.exp = pack(v, c, a, b, fe, ov);
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        bit slow;
        tbl[0]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h01, 1,  0, 8'h01, 8'h00, 1, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 1,  0, 8'h01, 8'h00, 1, 0, 0);
        tbl[3]  = mk(0, 1, 8'h05, 1,  1, 8'h01, 8'h05, 1, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1,  0, 8'h01, 8'h05, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'h03, 0,  0, 8'h03, 8'h05, 1, 0, 0);
        tbl[6]  = mk(0, 1, 8'h20, 0,  0, 8'h03, 8'h05, 0, 1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 0,  0, 8'h03, 8'h05, 0, 0, 0);
        tbl[8]  = mk(0, 1, 8'h03, 0,  0, 8'h03, 8'h05, 1, 0, 0);
        tbl[9]  = mk(0, 1, 8'h1F, 0,  1, 8'h03, 8'h1F, 1, 0, 0);
        tbl[10] = mk(0, 1, 8'h09, 0,  1, 8'h03, 8'h1F, 1, 0, 1);
        tbl[11] = mk(0, 0, 8'h00, 0,  1, 8'h03, 8'h1F, 1, 0, 0);
        tbl[12] = mk(0, 1, 8'h07, 1,  0, 8'h03, 8'h1F, 0, 0, 1);
        tbl[13] = mk(0, 1, 8'h02, 1,  0, 8'h02, 8'h1F, 1, 0, 0);
        tbl[14] = mk(1, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        tbl[15] = mk(0, 1, 8'h04, 0,  0, 8'h04, 8'h00, 1, 0, 0);
        tbl[16] = mk(0, 1, 8'h06, 0,  1, 8'h04, 8'h06, 1, 0, 0);
        tbl[17] = mk(1, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        tbl[18] = mk(0, 1, 8'h01, 0,  0, 8'h01, 8'h00, 1, 0, 0);
        tbl[19] = mk(0, 1, 8'h05, 1,  1, 8'h01, 8'h05, 1, 0, 0);
        tbl[20] = mk(0, 0, 8'h00, 1,  0, 8'h01, 8'h05, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].hd, tbl[i].d, tbl[i].rdy);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Command followed by 20 idle cycles: timeout fires on the 16th idle cycle when built.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 8'h00, 0);
            if (i == 15) check1("fe_before_timeout", frame_error, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
            if (i == 16) check1("fe_timeout", frame_error, 1'b1);
            if (i == 17) check1("busy_after_timeout", busy, 1'b0);
`else
            if (i == 16) check1("fe_no_timeout", frame_error, 1'b0);
            if (i == 20) check1("busy_waiting", busy, 1'b1);
`endif
        end

        // Address byte arriving in the timeout cycle itself is accepted.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        for (int i = 1; i <= 15; i++) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h04, 0);
        check1("edge_valid", request_valid, 1'b1);
        check1("edge_no_fe", frame_error, 1'b0);
        step(0, 0, 8'h00, 1);

        // Long gap between command and address.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        for (int i = 0; i < 1000; i++) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h04, 1);
`ifndef UART_CMD_TIMEOUT_EN
        check("long_gap_issue", dut_out(), pack(1, 8'h02, 8'h04, 1, 0, 0));
`endif
        step(0, 0, 8'h00, 1);

        // Pending request held 50 cycles while a byte is dropped.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h05, 0);
        for (int i = 0; i < 50; i++) begin
            step(0, (i == 10), 8'h09, 0);
            check1("hold_valid", request_valid, 1'b1);
            if (i == 10) check("overrun_pulse", dut_out(), pack(1, 8'h01, 8'h05, 1, 0, 1));
            if (i == 11) check1("overrun_once", overrun, 1'b0);
        end
        step(0, 0, 8'h00, 1);
        check1("hold_release", request_valid, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

        // Randomized traffic with alternating dense and sparse byte arrival.
        step(1, 0, 8'h00, 0);
        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) slow = ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 199) == 0,
                 slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 9) < 4),
                 8'($urandom_range(0, 40)),
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_command_sequencer.md
# uart_command_sequencer

Sequences the byte stream from the UART receiver into two-byte sensor requests (command byte, then sensor address byte) and presents each complete request to the sensor-access logic with a valid/ready handshake. Sits between the UART RX datapath (`has_data` strobe, 8-bit `data_received`) and the sensor controller. It rejects malformed frames and flags bytes lost while a request is pending.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in clock cycles between the command and address bytes; legal range 1 to 2^24-1.
- `MAX_ADDRESS`, default 31: highest legal sensor address; larger addresses are rejected.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `has_data`  in  1  one-cycle strobe from the UART receiver: a byte is available.
- `data_received`  in  8  received byte; valid in the `has_data` cycle.
- `request_ready`  in  1  downstream accepts the pending request.
- `request_valid`  out  1  a complete request is presented.
- `request_command`  out  8  command byte of the pending request.
- `request_address`  out  8  address byte of the pending request.
- `busy`  out  1  high whenever the state is not WAIT_COMMAND.
- `frame_error`  out  1  one-cycle pulse: frame discarded (timeout or bad address).
- `overrun`  out  1  one-cycle pulse: byte dropped because a request was pending.

## Operation
- States: WAIT_COMMAND, WAIT_ADDRESS, ISSUE. Reset state is WAIT_COMMAND.
- WAIT_COMMAND:
  - On `has_data`, latch `data_received` into `request_command`, clear the timer, and go to WAIT_ADDRESS.
- WAIT_ADDRESS:
  - The 24-bit timer increments every cycle without `has_data`.
  - On `has_data` with byte <= `MAX_ADDRESS` (unsigned compare): latch the byte into `request_address` and go to ISSUE.
  - On `has_data` with byte > `MAX_ADDRESS`: pulse `frame_error` and return to WAIT_COMMAND; the byte is discarded.
  - Timeout: if the timer equals `TIMEOUT_CYCLES-1` with no `has_data` in that cycle, pulse `frame_error` and return to WAIT_COMMAND.
  - If `has_data` arrives in the timeout cycle, the byte wins and is processed normally.
- ISSUE:
  - `request_valid`=1; `request_command` and `request_address` are held stable.
  - When `request_ready`=1, the handshake completes and the state returns to WAIT_COMMAND.
  - Any `has_data` while in ISSUE, including the handshake cycle, drops the byte and pulses `overrun` in the next cycle. The state is not otherwise affected.
- `request_command` and `request_address` keep their last values after the handshake; they are meaningful only while `request_valid` is high.
- Reset mid-operation: any partial frame or pending request is discarded; no error pulse is generated.

## Timing
- Reset values: `request_valid`=0, `request_command`=0x00, `request_address`=0x00, `busy`=0, `frame_error`=0, `overrun`=0, timer=0.
- All outputs are registered.
- `request_valid` rises in the cycle after the address byte's `has_data` cycle (latency 1).
- `request_valid` falls in the cycle after a `request_ready`=1 cycle. A new command byte is accepted from that cycle onward.
- `frame_error` is asserted in the cycle after the offending event, for exactly 1 cycle.
- `overrun` is asserted in the cycle after the dropped `has_data`, for exactly 1 cycle.
- `busy` rises in the cycle after the command byte's `has_data` cycle.
- `request_ready` is ignored outside ISSUE.
- Back-to-back `has_data` on consecutive cycles is legal and processed in order.

## Configuration
- Macro `UART_CMD_TIMEOUT_EN`.
- Defined: the inter-byte timeout behaves as described above, and the timer is built.
- Undefined: no timer is built; WAIT_ADDRESS waits indefinitely. `frame_error` is raised only for bad addresses. `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then bytes 0x01, 0x05 spaced 10 cycles apart, `request_ready`=1 -> `request_valid` for 1 cycle, the cycle after the second strobe; command 0x01, address 0x05; `busy` returns to 0.
- Bytes 0x03, 0x20 (`MAX_ADDRESS`=31) -> no `request_valid`; `frame_error` 1-cycle pulse; the next pair 0x03, 0x1F is issued normally.
- `TIMEOUT_CYCLES`=16, with the macro defined: byte 0x02 followed by 20 idle cycles -> `frame_error` pulse 16 cycles after the latch; state returns to WAIT_COMMAND. The second byte arriving exactly in the timeout cycle -> request issued, no error.
- Macro undefined: byte 0x02, 1000 idle cycles, then 0x04 -> request issued with command 0x02, address 0x04; no `frame_error`.
- Request pending with `request_ready`=0 for 50 cycles while byte 0x09 arrives -> `overrun` pulse; request stays 0x01/0x05 until ready; 0x09 is never issued.
- Reset asserted in WAIT_ADDRESS and in ISSUE -> all outputs 0 the next cycle; no `frame_error`; a following full frame is issued correctly.
